// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state type and bit-timing helper.
// Both the receiver and the transmitter take their timing from here.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 100_000_000;
    localparam int BAUDRATE_DEF = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Clocks per bit. The transmitter's counter runs 0..CLK_FREQ/BAUDRATE
    // inclusive, so one bit lasts one clock longer than the plain ratio.
    function automatic int bit_cycles(input int clk_freq, input int baudrate);
        return clk_freq / baudrate + 1;
    endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Byte-side bundle of the UART receiver: received byte, valid/ack handshake
// and status flags. The receiver drives it through 'master'; the consumer
// uses 'slave'.
interface uart_recv_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ack
    );

endinterface

// File: rtl/uart_recv_sync_2ff.sv
// One-bit two-flop synchronizer for an asynchronous input.
// RST_VAL sets both flops on reset so an idle line does not look like an edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage shift into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver. Samples each bit at its centre, checks the first stop
// bit, and holds one received byte behind a valid/ack handshake with
// overrun and framing-error reporting.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = CLK_FREQ_DEF,
    parameter int BAUDRATE    = BAUDRATE_DEF,
    parameter int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUDRATE),
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_recv_if.master  bus
);

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);

    logic rx_s;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        load;
    logic        ferr;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // FSM and datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic: bit timing, centre sampling and frame checks.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        shreg_n = shreg;
        load    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Half a bit in: a start bit that is gone by now was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so a frame with one stop bit can be
                // followed immediately by the next start bit.
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must not be taken as a stream of start bits.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Output byte register and handshake; a load in the same cycle as an
    // ack wins, and the ack then only consumes the previous byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr;
            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_valid && !bus.rx_ack)
                    overrun <= 1'b1;
                else if (rx_valid && bus.rx_ack)
                    overrun <= 1'b0;
            end else if (bus.rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.overrun   = overrun;
    assign bus.frame_err = frame_err;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv with short bit timing. A frame-level model
// schedules, for each frame driven, the cycle where the byte must appear
// (or the framing error must pulse) and applies the handshake rules; one
// process compares every cycle, and directed checks pin literal values.
module tb_uart_recv;

    localparam int BIT  = 16;
    localparam int HALF = 8;
    // Edge (counted from the edge before the start bit is driven) on which the
    // stop-bit decision happens: 2 synchronizer edges, 1 IDLE edge, then
    // HALF + 9*BIT of bit timing.
    localparam int LOAD_E = 9 * BIT + HALF + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_recv_if bus ();

    uart_recv #(
        .BIT_CYCLES  (BIT),
        .HALF_CYCLES (HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int checks   = 0;
    int errors   = 0;
    int ferr_cnt = 0;

    logic [8:0] sched[int];     // cycle -> {stop bit, data}
    bit         busy_log[int];

    logic [7:0] m_data;
    logic       m_valid, m_ovr, m_ferr;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        sched.delete();
    endtask

    // Frame-level model plus per-cycle compare.
    initial begin : model
        logic       ack;
        logic [8:0] ev;
        bit         has;
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            ack    = bus.rx_ack;
            m_ferr = 1'b0;
            if (rst) begin
                model_reset();
            end else begin
                has = sched.exists(cyc);
                ev  = 9'h0;
                if (has) begin
                    ev = sched[cyc];
                    sched.delete(cyc);
                end
                if (has && ev[8]) begin
                    if (m_valid) m_ovr = !ack;
                    m_data  = ev[7:0];
                    m_valid = 1'b1;
                end else if (has) begin
                    m_ferr = 1'b1;
                end else if (ack && m_valid) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) model_reset();
            chk("rx_data",   bus.rx_data,            m_data);
            chk("rx_valid",  {7'd0, bus.rx_valid},   {7'd0, m_valid});
            chk("overrun",   {7'd0, bus.overrun},    {7'd0, m_ovr});
            chk("frame_err", {7'd0, bus.frame_err},  {7'd0, m_ferr});
            busy_log[cyc] = bus.busy;
            if (bus.frame_err) ferr_cnt++;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame, edge by edge. ack_e: edge with rx_ack high (0 = none);
    // low_ext: cycles the line stays low from the stop bit on; rst_e: edge
    // where a 3-cycle reset starts (0 = none). Called #1 after a clock edge.
    task automatic send(input logic [7:0] d, input logic stop, input int nstop,
                        input int ack_e, input int low_ext, input int rst_e,
                        output int n0);
        int   total;
        int   k;
        logic b;
        total = (9 + nstop) * BIT;
        n0 = cyc;
        sched[n0 + LOAD_E] = {stop, d};
        for (int e = 1; e <= total; e++) begin
            k = (e - 1) / BIT;
            if (k == 0)      b = 1'b0;
            else if (k <= 8) b = d[k-1];
            else if (k == 9) b = stop;
            else             b = 1'b1;
            if (e > 9 * BIT && e <= 9 * BIT + low_ext) b = 1'b0;
            rx = b;
            bus.rx_ack = (e == ack_e);
            if (rst_e > 0 && e == rst_e)     rst = 1'b1;
            if (rst_e > 0 && e == rst_e + 3) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        rx = 1'b1;
        bus.rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
    endtask

    initial begin : stim
        int         n;
        int         f0;
        logic [7:0] b;
        bus.rx_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_data",  bus.rx_data, 8'h00);
        chk("reset_valid", {7'd0, bus.rx_valid}, 8'h00);
        chk("reset_busy",  {7'd0, bus.busy}, 8'h00);
        rst = 1'b0;
        idle(5);

        // 1: single frame
        send(8'hA5, 1'b1, 1, 0, 0, 0, n);
        chk("t1_data",  bus.rx_data, 8'hA5);
        chk("t1_valid", {7'd0, bus.rx_valid}, 8'h01);
        chk("t1_busy_before", {7'd0, busy_log[n + LOAD_E - 1]}, 8'h01);
        chk("t1_busy_after",  {7'd0, busy_log[n + LOAD_E + 1]}, 8'h00);
        ack_pulse();
        chk("t1_acked", {7'd0, bus.rx_valid}, 8'h00);

        // 2: back-to-back single-stop frames, acked between
        send(8'h3C, 1'b1, 1, 10 * BIT, 0, 0, n);
        chk("t2_first", bus.rx_data, 8'h3C);
        send(8'hC3, 1'b1, 1, 10 * BIT, 0, 0, n);
        chk("t2_second", bus.rx_data, 8'hC3);
        chk("t2_ovr", {7'd0, bus.overrun}, 8'h00);

        // 3: overrun, then ack clears both flags
        send(8'h11, 1'b1, 1, 0, 0, 0, n);
        send(8'h22, 1'b1, 1, 0, 0, 0, n);
        chk("t3_data", bus.rx_data, 8'h22);
        chk("t3_ovr",  {7'd0, bus.overrun}, 8'h01);
        ack_pulse();
        chk("t3_valid_clr", {7'd0, bus.rx_valid}, 8'h00);
        chk("t3_ovr_clr",   {7'd0, bus.overrun}, 8'h00);

        // load and ack on the same edge: load wins, no overrun
        send(8'h33, 1'b1, 1, 0, 0, 0, n);
        send(8'h44, 1'b1, 1, LOAD_E, 0, 0, n);
        chk("t3b_data",  bus.rx_data, 8'h44);
        chk("t3b_valid", {7'd0, bus.rx_valid}, 8'h01);
        chk("t3b_ovr",   {7'd0, bus.overrun}, 8'h00);
        ack_pulse();

        // 4: bad stop bit, line held low, then released
        f0 = ferr_cnt;
        send(8'h55, 1'b0, 4, 0, 40, 0, n);
        idle(20);
        chk("t4_ferr_pulses", 8'(ferr_cnt - f0), 8'h01);
        chk("t4_valid", {7'd0, bus.rx_valid}, 8'h00);
        chk("t4_data_kept", bus.rx_data, 8'h44);
        chk("t4_busy_break", {7'd0, busy_log[n + 180]}, 8'h01);
        chk("t4_busy_idle",  {7'd0, busy_log[n + 200]}, 8'h00);

        // 5: 4-cycle glitch
        n = cyc;
        rx = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        idle(30);
        chk("t5_glitch_busy",  {7'd0, busy_log[n + 6]},  8'h01);
        chk("t5_glitch_hold",  {7'd0, busy_log[n + 10]}, 8'h01);
        chk("t5_glitch_idle",  {7'd0, busy_log[n + 13]}, 8'h00);
        chk("t5_glitch_valid", {7'd0, bus.rx_valid}, 8'h00);

        // reset during data bit 4, with a byte still pending
        send(8'h5A, 1'b1, 1, 0, 0, 0, n);
        chk("t5_pending", bus.rx_data, 8'h5A);
        send(8'hF0, 1'b1, 1, 0, 0, 5 * BIT + 8, n);
        chk("t5_rst_data",  bus.rx_data, 8'h00);
        chk("t5_rst_valid", {7'd0, bus.rx_valid}, 8'h00);
        chk("t5_rst_busy",  {7'd0, bus.busy}, 8'h00);
        send(8'h81, 1'b1, 1, 10 * BIT, 0, 0, n);
        chk("t5_after_rst", bus.rx_data, 8'h81);

        // 6: 100 random bytes from a two-stop-bit transmitter
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1, 2, 10 * BIT, 0, 0, n);
            chk("t6_byte", bus.rx_data, b);
        end
        idle(5);
        chk("total_ferr", 8'(ferr_cnt), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
